// File: rtl/approx_mult_stream_pkg.sv
// Shared types and helpers for the leading-one-truncation approximate multiplier.
// Holds the default widths, the controller state encoding and the mantissa rounding.
package approx_mult_stream_pkg;

    localparam int DEFAULT_W = 16;
    localparam int DEFAULT_K = 8;
    localparam int MAXW      = 64;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        OUT
    } stateT;

    // Wide enough to hold sa+sb, whose maximum is 2W-2.
    function automatic int shiftWidth(input int w);
        return $clog2(2 * w - 1);
    endfunction

    // Top k bits of a normalised w-bit value, optionally rounded half-up.
    // An all-ones mantissa saturates rather than carrying out of k bits.
    function automatic logic [MAXW-1:0] roundMant(
        input logic [MAXW-1:0] x,
        input int              w,
        input int              k,
        input logic            rnd
    );
        logic [MAXW-1:0] allOnes;
        logic [MAXW-1:0] t;
        allOnes = (MAXW'(1) << k) - MAXW'(1);
        t       = (x >> (w - k)) & allOnes;
        if (rnd && (k < w)) begin
            if (x[w-k-1] && (t != allOnes)) begin
                t = t + MAXW'(1);
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/approx_mult_stream_lz_norm_shifter.sv
// Loadable left-shift register that normalises one operand until its MSB is set,
// counting the shifts taken. done is simply the current MSB.
module lz_norm_shifter #(
    parameter int W  = 16,
    parameter int SW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic [W-1:0]  loadVal,
    input  logic          shiftEn,
    output logic [W-1:0]  value,
    output logic [SW-1:0] count,
    output logic          done
);

    logic [W-1:0]  valueReg;
    logic [SW-1:0] countReg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valueReg <= '0;
            countReg <= '0;
        end else if (clr) begin
            valueReg <= '0;
            countReg <= '0;
        end else if (load) begin
            valueReg <= loadVal;
            countReg <= '0;
        end else if (shiftEn && !valueReg[W-1]) begin
            valueReg <= valueReg << 1;
            countReg <= countReg + SW'(1);
        end
    end

    assign value = valueReg;
    assign count = countReg;
    assign done  = valueReg[W-1];

endmodule

// File: rtl/approx_mult_stream.sv
// Streaming approximate multiplier: normalise both operands, truncate to K bits,
// multiply the mantissas and shift the product back into a 2W-bit result.
module approx_mult_stream
    import approx_mult_stream_pkg::*;
#(
    parameter int W  = DEFAULT_W,
    parameter int K  = DEFAULT_K,
    parameter int SW = shiftWidth(W)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    input  logic           in_rnd,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*K-1:0] out_prod,
    output logic [SW-1:0]  out_shamt,
    output logic [2*W-1:0] out_res,
    output logic           out_zero
);

    stateT stateReg, stateNext;
    logic  rndReg, rndNext;

    logic           outValidReg, outValidNext;
    logic [2*K-1:0] outProdReg, outProdNext;
    logic [SW-1:0]  outShamtReg, outShamtNext;
    logic [2*W-1:0] outResReg, outResNext;
    logic           outZeroReg, outZeroNext;

    logic [W-1:0]  opIn   [2];
    logic [W-1:0]  opVal  [2];
    logic [SW-1:0] opCnt  [2];
    logic          opDone [2];
    logic [K-1:0]  mant   [2];

    logic loadOps;
    logic shiftEn;

    logic [2*K-1:0] prodCalc;
    logic [SW-1:0]  shamtCalc;
    logic [2*W-1:0] prodWide;
    logic [2*W-1:0] resCalc;

    assign opIn[0] = in_a;
    assign opIn[1] = in_b;
    assign loadOps = (stateReg == IDLE) && in_valid;
    assign shiftEn = (stateReg == NORM);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : genOperand
            lz_norm_shifter #(
                .W  (W),
                .SW (SW)
            ) uShifter (
                .clk     (clk),
                .rst     (rst),
                .clr     (clr),
                .load    (loadOps),
                .loadVal (opIn[gi]),
                .shiftEn (shiftEn),
                .value   (opVal[gi]),
                .count   (opCnt[gi]),
                .done    (opDone[gi])
            );
            assign mant[gi] = K'(roundMant(MAXW'(opVal[gi]), W, K, rndReg));
        end
    endgenerate

    // Mantissas are at most K bits each, so the 2K-bit product cannot overflow.
    assign prodCalc  = (2*K)'(mant[0]) * (2*K)'(mant[1]);
    assign shamtCalc = opCnt[0] + opCnt[1];
    assign prodWide  = (2*W)'(prodCalc);
    assign resCalc   = (prodWide << (2 * (W - K))) >> shamtCalc;

    always_comb begin
        stateNext    = stateReg;
        rndNext      = rndReg;
        outValidNext = outValidReg;
        outProdNext  = outProdReg;
        outShamtNext = outShamtReg;
        outResNext   = outResReg;
        outZeroNext  = outZeroReg;
        if (clr) begin
            stateNext    = IDLE;
            rndNext      = 1'b0;
            outValidNext = 1'b0;
            outProdNext  = '0;
            outShamtNext = '0;
            outResNext   = '0;
            outZeroNext  = 1'b0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (in_valid) begin
                        rndNext = in_rnd;
                        // A zero operand would never normalise; bypass straight to OUT.
                        if ((in_a == '0) || (in_b == '0)) begin
                            stateNext    = OUT;
                            outValidNext = 1'b1;
                            outProdNext  = '0;
                            outShamtNext = '0;
                            outResNext   = '0;
                            outZeroNext  = 1'b1;
                        end else begin
                            stateNext = NORM;
                        end
                    end
                end
                NORM: begin
                    if (opDone[0] && opDone[1]) begin
                        stateNext    = OUT;
                        outValidNext = 1'b1;
                        outProdNext  = prodCalc;
                        outShamtNext = shamtCalc;
                        outResNext   = resCalc;
                        outZeroNext  = 1'b0;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        stateNext    = IDLE;
                        outValidNext = 1'b0;
                    end
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg    <= IDLE;
            rndReg      <= 1'b0;
            outValidReg <= 1'b0;
            outProdReg  <= '0;
            outShamtReg <= '0;
            outResReg   <= '0;
            outZeroReg  <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            rndReg      <= rndNext;
            outValidReg <= outValidNext;
            outProdReg  <= outProdNext;
            outShamtReg <= outShamtNext;
            outResReg   <= outResNext;
            outZeroReg  <= outZeroNext;
        end
    end

    assign in_ready  = (stateReg == IDLE);
    assign out_valid = outValidReg;
    assign out_prod  = outProdReg;
    assign out_shamt = outShamtReg;
    assign out_res   = outResReg;
    assign out_zero  = outZeroReg;

endmodule

// File: tb/tb_approx_mult_stream.sv
// Directed bench for approx_mult_stream: default 16/8 build plus an 8/4 build.
module tb_approx_mult_stream;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        inValid;
    logic        inReady;
    logic [15:0] inA;
    logic [15:0] inB;
    logic        inRnd;
    logic        outValid;
    logic        outReady;
    logic [15:0] outProd;
    logic [4:0]  outShamt;
    logic [31:0] outRes;
    logic        outZero;

    logic        clr8;
    logic        inValid8;
    logic        inReady8;
    logic [7:0]  inA8;
    logic [7:0]  inB8;
    logic        inRnd8;
    logic        outValid8;
    logic        outReady8;
    logic [7:0]  outProd8;
    logic [3:0]  outShamt8;
    logic [15:0] outRes8;
    logic        outZero8;

    int vectors     = 0;
    int miscompares = 0;

    approx_mult_stream #(.W(16), .K(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_a      (inA),
        .in_b      (inB),
        .in_rnd    (inRnd),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_prod  (outProd),
        .out_shamt (outShamt),
        .out_res   (outRes),
        .out_zero  (outZero)
    );

    approx_mult_stream #(.W(8), .K(4)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr8),
        .in_valid  (inValid8),
        .in_ready  (inReady8),
        .in_a      (inA8),
        .in_b      (inB8),
        .in_rnd    (inRnd8),
        .out_valid (outValid8),
        .out_ready (outReady8),
        .out_prod  (outProd8),
        .out_shamt (outShamt8),
        .out_res   (outRes8),
        .out_zero  (outZero8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic rnd);
        @(negedge clk);
        inA     = a;
        inB     = b;
        inRnd   = rnd;
        inValid = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic waitValid(input string tag, input int expLat);
        int lat;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (outValid) begin
                lat = n;
                break;
            end
        end
        check({tag, " latency"}, lat, expLat);
    endtask

    task automatic handshake(input string tag);
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        check({tag, " out_valid drop"}, outValid, 0);
        check({tag, " in_ready back"}, inReady, 1);
    endtask

    task automatic checkResult(input string tag, input logic [15:0] prod, input logic [4:0] shamt,
                               input logic [31:0] res, input logic zero);
        check({tag, " prod"}, outProd, prod);
        check({tag, " shamt"}, outShamt, shamt);
        check({tag, " res"}, outRes, res);
        check({tag, " zero"}, outZero, zero);
    endtask

    task automatic checkNoValid(input string tag);
        logic seen;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (outValid) seen = 1'b1;
        end
        check({tag, " no result"}, seen, 0);
    endtask

    initial begin
        rst       = 1'b1;
        clr       = 1'b0;
        inValid   = 1'b0;
        inA       = '0;
        inB       = '0;
        inRnd     = 1'b0;
        outReady  = 1'b0;
        clr8      = 1'b0;
        inValid8  = 1'b0;
        inA8      = '0;
        inB8      = '0;
        inRnd8    = 1'b0;
        outReady8 = 1'b0;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", outValid, 0);
        check("reset in_ready", inReady, 1);
        checkResult("reset", 16'h0, 5'd0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Exact fit: sa=8, sb=14
        accept(16'h00F0, 16'h0003, 1'b0);
        check("exact in_ready in NORM", inReady, 0);
        waitValid("exact", 15);
        checkResult("exact", 16'hB400, 5'd22, 32'd720, 1'b0);
        handshake("exact");

        accept(16'h1234, 16'h8000, 1'b0);
        waitValid("trunc", 4);
        checkResult("trunc", 16'h4880, 5'd3, 32'h09100000, 1'b0);
        handshake("trunc");

        accept(16'h1234, 16'h8000, 1'b1);
        waitValid("round", 4);
        checkResult("round", 16'h4900, 5'd3, 32'h09200000, 1'b0);
        handshake("round");

        // All-ones mantissa must not round up
        accept(16'hFF80, 16'h8000, 1'b1);
        waitValid("sat", 1);
        checkResult("sat", 16'h7F80, 5'd0, 32'h7F800000, 1'b0);
        handshake("sat");

        accept(16'h0000, 16'h1234, 1'b0);
        waitValid("zero", 1);
        checkResult("zero", 16'h0, 5'd0, 32'h0, 1'b1);
        handshake("zero");

        // Backpressure with stray in_valid pulses
        accept(16'h1234, 16'h8000, 1'b0);
        waitValid("bp", 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            inA     = 16'hFFFF;
            inB     = 16'hFFFF;
            inValid = 1'b1;
            @(posedge clk);
            #1;
            inValid = 1'b0;
            check("bp hold valid", outValid, 1);
            check("bp in_ready low", inReady, 0);
            checkResult("bp hold", 16'h4880, 5'd3, 32'h09100000, 1'b0);
        end
        handshake("bp");
        checkNoValid("bp ignored pulses");

        // Asynchronous reset mid-NORM
        accept(16'h0001, 16'h0001, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst abort in NORM", inReady, 0);
        rst = 1'b0;
        #1;
        check("rst abort out_valid", outValid, 0);
        check("rst abort in_ready", inReady, 1);
        checkResult("rst abort", 16'h0, 5'd0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        checkNoValid("rst abort");

        // Synchronous clear mid-NORM, with stale data on the outputs
        accept(16'h00F0, 16'h0003, 1'b0);
        waitValid("pre clr", 15);
        handshake("pre clr");
        accept(16'h0001, 16'h0001, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("clr abort out_valid", outValid, 0);
        check("clr abort in_ready", inReady, 1);
        checkResult("clr abort", 16'h0, 5'd0, 32'h0, 1'b0);
        checkNoValid("clr abort");

        // 8/4 build: worst-case operands
        begin
            int lat8;
            lat8 = 0;
            @(negedge clk);
            inA8     = 8'h01;
            inB8     = 8'h01;
            inRnd8   = 1'b0;
            inValid8 = 1'b1;
            @(posedge clk);
            #1;
            inValid8 = 1'b0;
            for (int n = 1; n <= 40; n++) begin
                @(posedge clk);
                #1;
                if (outValid8) begin
                    lat8 = n;
                    break;
                end
            end
            check("w8 latency", lat8, 8);
            check("w8 prod", outProd8, 8'h40);
            check("w8 shamt", outShamt8, 4'd14);
            check("w8 res", outRes8, 16'd1);
            check("w8 zero", outZero8, 0);
            outReady8 = 1'b1;
            @(posedge clk);
            #1;
            outReady8 = 1'b0;
            check("w8 out_valid drop", outValid8, 0);
            check("w8 in_ready back", inReady8, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/approx_mult_stream.md
Name: approx_mult_stream

Overview:
Parametrised, streaming leading-one-truncation approximate multiplier core.
- Accepts one W-bit unsigned operand pair per transaction via valid/ready.
- Normalises both operands in parallel, one left shift per cycle each, and truncates them to K bits, with optional rounding.
- Multiplies the truncated operands and returns the K×K product, the combined shift count and the reconstructed 2W-bit approximate result through a one-entry output buffer.
- Drops in between an operand memory/sequencer and a result memory; replaces the fixed 16/8-bit, single-mode datapath.

Parameters:
W, 16, operand width (W >= 2).
K, 8, truncated mantissa width (2 <= K <= W).
SW, $clog2(2*W-1), shift-count width (derived; not overridden).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
clr  in  1  synchronous abort; returns to IDLE and clears all outputs.
in_valid  in  1  operand pair valid.
in_ready  out  1  core can accept (high only in IDLE).
in_a  in  W  operand A.
in_b  in  W  operand B.
in_rnd  in  1  rounding mode, sampled at accept; 0 = truncate, 1 = round-half-up.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
out_prod  out  2K  product of the truncated mantissas.
out_shamt  out  SW  sa+sb, the total normalising shifts.
out_res  out  2W  approximate product, computed as ({out_prod, 2(W-K) zeros}) >> out_shamt.
out_zero  out  1  an operand was zero.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; in_ready=1; out_valid=0; out_prod, out_shamt, out_res and out_zero=0; internal operand registers and counters=0.
- clr=1 (synchronous): identical effect at the next edge. clr has priority over every other input.
- States: IDLE, NORM, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid=1, latch A, B and rnd, clear both shift counters and go to NORM.
  - If A==0 or B==0: go directly to OUT with out_prod=0, out_shamt=0, out_res=0, out_zero=1.
- NORM, each cycle, for each operand X:
  - If X[W-1]=0, X<=X<<1 and its counter increments.
  - Otherwise X holds and is marked done.
  - At the edge where both operands are done: compute the mantissas, load the output register, set out_valid=1 and go to OUT.
- Latency: out_valid rises max(sa,sb)+1 edges after the accept edge (sa,sb = leading-zero counts).
  - Example: both MSBs set -> 1 cycle.
  - Worst case (operand 1) -> W cycles.
- Mantissa of normalised X:
  - t = X[W-1:W-K].
  - If rnd=1, K<W, X[W-K-1]=1 and t != all-ones, then t=t+1.
  - All-ones saturates: no increment, no carry-out.
- Product and result:
  - out_prod = tA*tB, full 2K bits, no overflow possible.
  - out_shamt = sa+sb (maximum 2W-2).
  - out_res is computed combinationally from the registered values, or registered at the same edge; either way it must be stable while out_valid=1.
- OUT:
  - Outputs are held stable while out_valid=1 and out_ready=0.
  - in_ready=0 and in_valid is ignored.
  - On out_ready=1: out_valid drops at the next edge and the state returns to IDLE. Data outputs keep their last values until the next load.
- Throughput: no overlap; the next accept is earliest one cycle after the output handshake.
- Reset or clr during NORM or OUT: the transaction is discarded and no result is emitted.

Decomposition:
- Shared package:
  - localparams W/K defaults and SW derivation function.
  - state enum {IDLE, NORM, OUT}.
  - mantissa-rounding function.
- One natural sub-module, lz_norm_shifter (instanced twice):
  - W-bit loadable left-shift register with done flag and shift counter.
  - Successor of the existing shift-register/counter pair.
- Controller FSM, multiplier and barrel right shift stay in the top module.

Test Plan:
- Exact-fit case: W=16, K=8, a=0x00F0, b=0x0003, rnd=0 -> sa=8, sb=14, out_prod=0xB400, out_shamt=22, out_res=720, out_valid rises 15 cycles after accept.
- Truncate vs round: a=0x1234, b=0x8000.
  - rnd=0 -> out_prod=0x4880, out_shamt=3, out_res=0x09100000.
  - rnd=1 -> out_prod=0x4900, out_res=0x09200000.
  - Latency 4 cycles in both modes.
- Saturation and MSB-set case: a=0xFF80, b=0x8000, rnd=1 -> mantissa stays 0xFF, out_prod=0x7F80, out_shamt=0, out_res=0x7F800000, latency 1 cycle.
- Zero operand: a=0, b=0x1234 -> out_zero=1, out_prod=0, out_res=0, out_shamt=0, out_valid 1 cycle after accept.
- Backpressure and abort:
  - out_ready held low 5 cycles -> outputs stable, in_ready=0, extra in_valid pulses ignored.
  - Then out_ready=1 -> IDLE, in_ready=1 next cycle.
  - Separate run: assert rst low mid-NORM -> all outputs 0 immediately, no out_valid afterwards. Repeat the abort with clr.
- Parametrised build: W=8, K=4, a=0x01, b=0x01 -> sa=sb=7, out_prod=0x40, out_shamt=14, out_res=1, latency 8 cycles.
